// File: rtl/uarttx.sv
// UART transmitter draining a BRAM FIFO read port: start bit, DATA_ bits LSB first,
// optional parity bit, STOP_ stop bits. All outputs are registered.
module uarttx #(
  parameter int DATA_   = 8,
  parameter int ADDR_   = 8,
  parameter int CLKDIV_ = 16,
  parameter int PARITY_ = 0,
  parameter int STOP_   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ADDR_:0]   fillc,
  input  logic [DATA_-1:0] fdata,
  output logic             re,
  output logic             tx,
  output logic             busy
);

  localparam int DIV_W = $clog2(CLKDIV_);
  localparam int BIT_W = $clog2(DATA_ + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKDIV_ - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_ - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_ - 1);
  localparam logic [ADDR_:0]   FILL_ZERO = (ADDR_ + 1)'(0);

  if (CLKDIV_ < 2) begin : g_bad_clkdiv
    $error("uarttx: CLKDIV_ must be at least 2");
  end
  if ((STOP_ != 1) && (STOP_ != 2)) begin : g_bad_stop
    $error("uarttx: STOP_ must be 1 or 2");
  end
  if ((PARITY_ < 0) || (PARITY_ > 2)) begin : g_bad_parity
    $error("uarttx: PARITY_ must be 0, 1 or 2");
  end
  if ((DATA_ < 5) || (DATA_ > 9)) begin : g_bad_data
    $error("uarttx: DATA_ must be in 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Even mode sends the XOR of the data bits, odd mode its complement.
  function automatic logic parity_f(input logic [DATA_-1:0] d);
    if (PARITY_ == 2) begin
      parity_f = ~(^d);
    end else begin
      parity_f = ^d;
    end
  endfunction

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_-1:0]   shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               re_q, re_d;
  logic               busy_q, busy_d;
  logic               div_wrap;

  // Next-state, divider/bit counters and registered-output decode.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    re_d     = 1'b0;
    div_wrap = (div_q == DIV_LAST);
    case (state_q)
      S_IDLE: begin
        div_d = DIV_ZERO;
        bit_d = BIT_ZERO;
        if (en && (fillc != FILL_ZERO)) begin
          state_d = S_START;
          shift_d = fdata;
          par_d   = parity_f(fdata);
          re_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (div_wrap) begin
          div_d   = DIV_ZERO;
          bit_d   = BIT_ZERO;
          state_d = S_DATA;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_DATA: begin
        if (div_wrap) begin
          div_d   = DIV_ZERO;
          shift_d = {1'b0, shift_q[DATA_-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = BIT_ZERO;
            state_d = (PARITY_ != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_PARITY: begin
        if (div_wrap) begin
          div_d   = DIV_ZERO;
          bit_d   = BIT_ZERO;
          state_d = S_STOP;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_STOP: begin
        if (div_wrap) begin
          div_d = DIV_ZERO;
          if (bit_q == STOP_LAST) begin
            bit_d   = BIT_ZERO;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = DIV_ZERO;
        bit_d   = BIT_ZERO;
      end
    endcase

    // Line level follows the state being entered so tx changes with the state flop.
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= DIV_ZERO;
      bit_q   <= BIT_ZERO;
      shift_q <= {DATA_{1'b0}};
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign re   = re_q;
  assign busy = busy_q;

endmodule
